// File: rtl/dmem_responder.sv
// Data-memory responder for the load/store port: one request at a time, optional wait states,
// RV32I byte/half/word access with load extension and misalignment/illegal-size errors.
`timescale 1ns/1ps
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned AW    = DEPTH_LOG2 + 2;
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            accept;
  logic            mem_we;
  logic            access_err;
  logic [3:0]      byte_en;
  logic [31:0]     wr_word;
  logic [31:0]     rd_word;
  logic [31:0]     load_val;
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]     mem_q [DEPTH];

  // Upper address bits beyond the array only wrap, so they are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW];

  assign idx     = addr_q[AW-1:2];
  assign rd_word = mem_q[idx];
  assign accept  = req_valid & req_ready;

  always_comb begin
    case (f3_q)
      3'b000:  access_err = 1'b0;
      3'b001:  access_err = addr_q[0];
      3'b010:  access_err = |addr_q[1:0];
      3'b100:  access_err = we_q;
      3'b101:  access_err = we_q | addr_q[0];
      default: access_err = 1'b1;
    endcase
  end

  always_comb begin
    byte_en = '0;
    wr_word = '0;
    case (f3_q[1:0])
      2'b00: begin
        byte_en = 4'b0001 << addr_q[1:0];
        wr_word = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata_q[15:0]}};
      end
      2'b10: begin
        byte_en = 4'b1111;
        wr_word = wdata_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    sel_byte = rd_word[{addr_q[1:0], 3'b000} +: 8];
    sel_half = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (f3_q)
      3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'd0, sel_byte};
      3'b101:  load_val = {16'd0, sel_half};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = reset;
        if (req_valid) begin
          state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        mem_we  = we_q & ~access_err;
        rdata_d = (we_q | access_err) ? '0 : load_val;
        err_d   = access_err;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[AW-1:0];
        wdata_q <= req_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) mem_q[idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table through a scoreboard on a one-wait-state instance,
// plus hand sequences for RESP hold, reset mid-operation and zero-wait back-to-back loads.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int unsigned WS = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [2:0]  b_req_funct3;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
  logic [31:0] b_rsp_rdata;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .busy(b_busy)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          hold;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_accept", id), 32'(req_ready), 32'd1);
    sb_q.push_back('{v.exp_rdata, v.exp_err});
    @(posedge clk);
    #1;
    // Scramble the request bus: only the accepted values may matter.
    req_valid  = 1'b0;
    req_we     = ~v.we;
    req_funct3 = 3'b111;
    req_addr   = ~v.addr;
    req_wdata  = ~v.wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    check($sformatf("v%0d_latency", id), 32'(n), 32'(2 + WS));
    e = sb_q.pop_front();
    check($sformatf("v%0d_rdata", id), rsp_rdata, e.rdata);
    check($sformatf("v%0d_err", id), 32'(rsp_err), 32'(e.err));
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      check($sformatf("v%0d_hold%0d_valid", id, h), 32'(rsp_valid), 32'd1);
      check($sformatf("v%0d_hold%0d_rdata", id, h), rsp_rdata, e.rdata);
      check($sformatf("v%0d_hold%0d_err", id, h), 32'(rsp_err), 32'(e.err));
      check($sformatf("v%0d_hold%0d_rdy", id, h), 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check($sformatf("v%0d_idle", id), 32'({busy, rsp_valid, req_ready}), 32'b001);
  endtask

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata,
                     input logic exp_err, input int hold);
    vecs.push_back('{we, f3, addr, wdata, exp_rdata, exp_err, hold});
  endtask

  initial begin
    int n;
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_funct3 = '0; b_req_addr = '0; b_req_wdata = '0;
    b_rsp_ready = 1'b1;

    //            we    f3      addr           wdata          exp_rdata      err  hold
    add(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0);
    add(1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 5);
    add(1'b1, 3'b010, 32'h0000_0020, 32'h1122_3344, 32'h0,         1'b0, 0);
    add(1'b1, 3'b000, 32'h0000_0021, 32'hFFFF_FF80, 32'h0,         1'b0, 0);
    add(1'b0, 3'b000, 32'h0000_0021, 32'h0,         32'hFFFF_FF80, 1'b0, 0);
    add(1'b0, 3'b100, 32'h0000_0021, 32'h0,         32'h0000_0080, 1'b0, 0);
    add(1'b0, 3'b010, 32'h0000_0020, 32'h0,         32'h1122_8044, 1'b0, 0);
    add(1'b0, 3'b001, 32'h0000_0022, 32'h0,         32'h0000_1122, 1'b0, 0);
    add(1'b0, 3'b001, 32'h0000_0020, 32'h0,         32'hFFFF_8044, 1'b0, 0);
    add(1'b0, 3'b101, 32'h0000_0020, 32'h0,         32'h0000_8044, 1'b0, 0);
    add(1'b1, 3'b001, 32'h0000_0022, 32'hFFFF_A5F0, 32'h0,         1'b0, 0);
    add(1'b0, 3'b010, 32'h0000_0020, 32'h0,         32'hA5F0_8044, 1'b0, 0);
    add(1'b0, 3'b000, 32'h0000_0023, 32'h0,         32'hFFFF_FFA5, 1'b0, 0);
    add(1'b0, 3'b000, 32'h0000_0020, 32'h0,         32'h0000_0044, 1'b0, 0);
    add(1'b0, 3'b001, 32'h0000_0013, 32'h0,         32'h0,         1'b1, 0);
    add(1'b1, 3'b010, 32'h0000_0014, 32'hCAFE_F00D, 32'h0,         1'b0, 0);
    add(1'b1, 3'b010, 32'h0000_0016, 32'h5555_5555, 32'h0,         1'b1, 0);
    add(1'b0, 3'b010, 32'h0000_0014, 32'h0,         32'hCAFE_F00D, 1'b0, 0);
    add(1'b1, 3'b100, 32'h0000_0014, 32'h0,         32'h0,         1'b1, 0);
    add(1'b1, 3'b101, 32'h0000_0014, 32'h0,         32'h0,         1'b1, 0);
    add(1'b1, 3'b001, 32'h0000_0015, 32'h0,         32'h0,         1'b1, 0);
    add(1'b1, 3'b111, 32'h0000_0014, 32'h0,         32'h0,         1'b1, 0);
    add(1'b0, 3'b010, 32'h0000_0014, 32'h0,         32'hCAFE_F00D, 1'b0, 0);
    add(1'b0, 3'b011, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 0);
    add(1'b0, 3'b110, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 0);
    add(1'b0, 3'b111, 32'h0000_0010, 32'h0,         32'h0,         1'b1, 0);
    add(1'b0, 3'b010, 32'h0000_0012, 32'h0,         32'h0,         1'b1, 0);
    add(1'b0, 3'b101, 32'h0000_0011, 32'h0,         32'h0,         1'b1, 0);
    add(1'b0, 3'b010, 32'h0000_0410, 32'h0,         32'hDEAD_BEEF, 1'b0, 0);
    add(1'b1, 3'b000, 32'h0000_0413, 32'h0000_0077, 32'h0,         1'b0, 0);
    add(1'b0, 3'b010, 32'h0000_0010, 32'h0,         32'h77AD_BEEF, 1'b0, 0);
    add(1'b0, 3'b101, 32'h0000_0012, 32'h0,         32'h0000_77AD, 1'b0, 0);
    add(1'b0, 3'b000, 32'h0000_0012, 32'h0,         32'hFFFF_FFAD, 1'b0, 0);
    add(1'b1, 3'b010, 32'h0000_0400, 32'h0BAD_F00D, 32'h0,         1'b0, 0);
    add(1'b0, 3'b010, 32'h0000_0000, 32'h0,         32'h0BAD_F00D, 1'b0, 0);
    add(1'b1, 3'b010, 32'h0000_03FC, 32'h89AB_CDEF, 32'h0,         1'b0, 0);
    add(1'b0, 3'b101, 32'h0000_03FE, 32'h0,         32'h0000_89AB, 1'b0, 0);
    add(1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0,         32'h89AB_CDEF, 1'b0, 0);

    repeat (2) @(negedge clk);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;

    // Zero-wait instance: a store then loads held valid with rsp_ready high; one response per 3 cycles.
    @(negedge clk);
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_funct3 = 3'b010;
    b_req_addr = 32'h0000_0400; b_req_wdata = 32'h0BAD_F00D;
    check("b_ready_idle", 32'(b_req_ready), 32'd1);
    @(posedge clk);
    #1;
    b_req_we = 1'b0; b_req_addr = 32'h0000_0000; b_req_wdata = '0;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      check($sformatf("b_valid_%0d", j), 32'(b_rsp_valid), 32'(j % 3 == 2));
      if (j % 3 == 2) begin
        check($sformatf("b_rdata_%0d", j), b_rsp_rdata, (j == 2) ? 32'h0 : 32'h0BAD_F00D);
        check($sformatf("b_err_%0d", j), 32'(b_rsp_err), 32'd0);
      end
    end
    b_req_valid = 1'b0;
    check("b_idle_end", 32'(b_busy), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset during WAIT drops the store.
    run_vec('{1'b1, 3'b010, 32'h40, 32'hAAAA_5555, 32'h0, 1'b0, 0}, 100);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("wait_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check("wrst_valid", 32'(rsp_valid), 32'd0);
    check("wrst_busy", 32'(busy), 32'd0);
    check("wrst_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    run_vec('{1'b0, 3'b010, 32'h40, 32'h0, 32'hAAAA_5555, 1'b0, 0}, 101);

    // Reset while a response is pending discards it.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    check("prst_pending", rsp_rdata, 32'h77AD_BEEF);
    reset = 1'b0;
    #1;
    check("prst_valid", 32'(rsp_valid), 32'd0);
    check("prst_rdata", rsp_rdata, 32'd0);
    check("prst_err", 32'(rsp_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("prst_idle", 32'({busy, req_ready}), 32'b01);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
